regfile_sb: RTL and testbench

Parametrised register file with two combinational read ports and one synchronous write port, aimed at the pipelined CPU's ID/WB stages. Entry 0 is hardwired to zero. A synchronous clear sequencer zeroes the array one entry per cycle after reset, so the storage can map to RAM without a parallel reset. A per-register busy scoreboard tells the ID stage when an operand is still owed by an in-flight instruction.

---
 rtl/regfile_sb.sv | 132 +++++++++++++
 tb/tb_regfile_sb.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, one write port, a post-reset clear sweep and a busy scoreboard.
// Define REGFILE_BYPASS_EN to add write-through bypass on both read ports.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [ADDR_W-1:0] rna,
    input  logic [ADDR_W-1:0] rnb,
    output logic [DATA_W-1:0] qa,
    output logic [DATA_W-1:0] qb,
    input  logic              we,
    input  logic [ADDR_W-1:0] wn,
    input  logic [DATA_W-1:0] d,
    input  logic              mark,
    input  logic [ADDR_W-1:0] mn,
    output logic              busy_a,
    output logic              busy_b,
    output logic              ready
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state;
    state_t            nextState;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busyNext;
    logic              run;
    logic              doWrite;

    assign run     = (state == RUN);
    assign doWrite = run && we && (wn != '0);

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= CLEAR;
        end else begin
            state <= nextState;
        end
    end

    // The sweep ends on the edge that clears the last entry.
    always_comb begin
        nextState = state;
        case (state)
            CLEAR:   if (cnt == '1) nextState = RUN;
            RUN:     nextState = RUN;
            default: nextState = CLEAR;
        endcase
    end

    always_comb begin
        ready = (state == RUN);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= ADDR_W'(1);
        end else if (state == CLEAR) begin
            cnt <= cnt + ADDR_W'(1);
        end
    end

    // Storage has no parallel reset so it can map onto RAM; the sweep zeroes it instead.
    always_ff @(posedge clk) begin
        if (!clr) begin
            if (state == CLEAR) begin
                mem[cnt] <= '0;
            end else if (doWrite) begin
                mem[wn] <= d;
            end
        end
    end

    // Mark is applied after the writeback clear so a same-cycle re-issue keeps the bit set.
    always_comb begin
        busyNext = busy;
        if (doWrite) busyNext[wn] = 1'b0;
        if (run && mark && (mn != '0)) busyNext[mn] = 1'b1;
        busyNext[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            busy <= '0;
        end else begin
            busy <= busyNext;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic hitA;
    logic hitB;

    assign hitA = doWrite && (wn == rna);
    assign hitB = doWrite && (wn == rnb);

    always_comb begin
        qa     = '0;
        qb     = '0;
        busy_a = 1'b0;
        busy_b = 1'b0;
        if (run) begin
            if (hitA)             qa = d;
            else if (rna != '0)   qa = mem[rna];
            if (hitB)             qb = d;
            else if (rnb != '0)   qb = mem[rnb];
            busy_a = busy[rna] && !hitA;
            busy_b = busy[rnb] && !hitB;
        end
    end
`else
    always_comb begin
        qa     = '0;
        qb     = '0;
        busy_a = 1'b0;
        busy_b = 1'b0;
        if (run) begin
            if (rna != '0) qa = mem[rna];
            if (rnb != '0) qb = mem[rnb];
            busy_a = busy[rna];
            busy_b = busy[rnb];
        end
    end
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb: clear sweep, read/write, bypass, scoreboard and reset.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        clr;
    logic [4:0]  rna, rnb, wn, mn;
    logic [31:0] qa, qb, d;
    logic        we, mark;
    logic        busy_a, busy_b, ready;

    int checks = 0;
    int errors = 0;
    int edges;

    regfile_sb #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .clr(clr), .rna(rna), .rnb(rnb), .qa(qa), .qb(qb),
        .we(we), .wn(wn), .d(d), .mark(mark), .mn(mn),
        .busy_a(busy_a), .busy_b(busy_b), .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic iwe, input logic [4:0] iwn, input logic [31:0] id,
                                 input logic imark, input logic [4:0] imn);
        we   = iwe;
        wn   = iwn;
        d    = id;
        mark = imark;
        mn   = imn;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until ready rises, bounded so a stuck sweep still reaches the summary.
    task automatic waitReady(output int n);
        n = 0;
        while (n < 40) begin
            stepClock();
            n++;
            if (ready) break;
        end
    endtask

    initial begin
        clr = 1'b1;
        rna = 5'd5;
        rnb = 5'd7;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        stepClock();
        stepClock();
        #1;
        checkOutput("reset_ready", {31'b0, ready}, 32'h0);
        checkOutput("reset_qa", qa, 32'h0);
        checkOutput("reset_busy_a", {31'b0, busy_a}, 32'h0);

        // Initial sweep with ignored writes and marks.
        clr = 1'b0;
        applyStimulus(1'b1, 5'd7, 32'hBAD0BAD0, 1'b1, 5'd7);
        waitReady(edges);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("sweep0_edges", edges, 32'd31);
        rna = 5'd7;
        #1;
        checkOutput("sweep0_r7", qa, 32'h0);
        checkOutput("sweep0_busy7", {31'b0, busy_a}, 32'h0);

        // Write r7, then restart the sweep.
        applyStimulus(1'b1, 5'd7, 32'h00001234, 1'b0, 5'd0);
        stepClock();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        #1;
        checkOutput("r7_written", qa, 32'h00001234);
        clr = 1'b1;
        stepClock();
        stepClock();
        checkOutput("clr_ready", {31'b0, ready}, 32'h0);
        checkOutput("clr_qa", qa, 32'h0);
        clr = 1'b0;
        applyStimulus(1'b1, 5'd7, 32'hCAFEF00D, 1'b0, 5'd0);
        waitReady(edges);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("sweep1_edges", edges, 32'd31);
        #1;
        checkOutput("sweep1_r7", qa, 32'h0);

        // Write/read and the zero register.
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
        stepClock();
        applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0);
        stepClock();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        rna = 5'd5;
        rnb = 5'd0;
        #1;
        checkOutput("rw_qa_r5", qa, 32'hDEADBEEF);
        checkOutput("rw_qb_r0", qb, 32'h0);
        rnb = 5'd5;
        #1;
        checkOutput("rw_qb_r5", qb, 32'hDEADBEEF);

        // Same-cycle write and read of r9.
        applyStimulus(1'b1, 5'd9, 32'h00000011, 1'b0, 5'd0);
        stepClock();
        applyStimulus(1'b1, 5'd9, 32'hA5A5A5A5, 1'b0, 5'd0);
        rna = 5'd9;
        #1;
`ifdef REGFILE_BYPASS_EN
        checkOutput("bypass_same", qa, 32'hA5A5A5A5);
`else
        checkOutput("bypass_same", qa, 32'h00000011);
`endif
        stepClock();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        #1;
        checkOutput("bypass_next", qa, 32'hA5A5A5A5);

        // Scoreboard set by mark, cleared by writeback.
        rna = 5'd3;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3);
        #1;
        checkOutput("sb_before_mark", {31'b0, busy_a}, 32'h0);
        stepClock();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        #1;
        checkOutput("sb_after_mark", {31'b0, busy_a}, 32'h1);
        applyStimulus(1'b1, 5'd3, 32'h00000033, 1'b0, 5'd0);
        #1;
`ifdef REGFILE_BYPASS_EN
        checkOutput("sb_wb_cycle", {31'b0, busy_a}, 32'h0);
`else
        checkOutput("sb_wb_cycle", {31'b0, busy_a}, 32'h1);
`endif
        stepClock();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        #1;
        checkOutput("sb_after_wb", {31'b0, busy_a}, 32'h0);
        checkOutput("sb_r3_data", qa, 32'h00000033);

        // Mark and writeback of r4 in the same cycle.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4);
        stepClock();
        applyStimulus(1'b1, 5'd4, 32'h00000077, 1'b1, 5'd4);
        stepClock();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        rna = 5'd4;
        rnb = 5'd3;
        #1;
        checkOutput("both_r4_data", qa, 32'h00000077);
        checkOutput("both_r4_busy", {31'b0, busy_a}, 32'h1);
        checkOutput("both_r3_idle", {31'b0, busy_b}, 32'h0);
        rna = 5'd0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
        stepClock();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        #1;
        checkOutput("mark_r0_busy", {31'b0, busy_a}, 32'h0);
        checkOutput("mark_r0_data", qa, 32'h0);

        // Reset pulse while r2 is busy and holds data.
        rna = 5'd2;
        applyStimulus(1'b1, 5'd2, 32'h00000022, 1'b0, 5'd0);
        stepClock();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd2);
        stepClock();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        #1;
        checkOutput("mid_busy_pre", {31'b0, busy_a}, 32'h1);
        checkOutput("mid_data_pre", qa, 32'h00000022);
        clr = 1'b1;
        stepClock();
        clr = 1'b0;
        checkOutput("mid_ready_drop", {31'b0, ready}, 32'h0);
        checkOutput("mid_busy_drop", {31'b0, busy_a}, 32'h0);
        checkOutput("mid_qa_drop", qa, 32'h0);
        waitReady(edges);
        checkOutput("mid_edges", edges, 32'd31);
        #1;
        checkOutput("mid_r2_zero", qa, 32'h0);
        checkOutput("mid_r2_idle", {31'b0, busy_a}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
